// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared defaults and helpers for the UART receive sampler.
package uart_rx_pkg;
    localparam int PRESCALE_W_DEF = 6;
    localparam int NUM_SAMPLES_DEF = 3;
    localparam logic RX_IDLE = 1'b1;
    function automatic int maj_threshold(input int n);
        return n / 2;
    endfunction
endpackage

// File: rtl/uart_rx_input_sync.sv
// uart_rx_input_sync: multi-stage synchroniser for the raw RX line, idling high.
module uart_rx_input_sync
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic UCLK,
    input  logic reset,
    input  logic serial_data_in,
    output logic rx_s
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge UCLK) begin
        if (reset) sync_q <= {SYNC_STAGES{RX_IDLE}};
        else sync_q <= {sync_q[SYNC_STAGES-2:0], serial_data_in};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_oversample_sampler.sv
// uart_rx_oversample_sampler: oversampling edge counter with centred
// majority-vote bit sampling, noise detection and prescale sanity checking.
module uart_rx_oversample_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = PRESCALE_W_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  serial_data_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    input  logic                  bit_start,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  bit_tick,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic                  cfg_err
);
    localparam int CW = PRESCALE_W + 1;
    localparam int NW = $clog2(NUM_SAMPLES + 1);
    localparam logic [CW-1:0] MIN_PRESCALE = CW'(NUM_SAMPLES + 1);
    localparam logic [NW-1:0] THRESH = NW'(maj_threshold(NUM_SAMPLES));

    logic                   rx_s;
    logic [PRESCALE_W-1:0]  prescale_q;
    logic [NUM_SAMPLES-1:0] samples_q, votes;
    logic [NW-1:0]          sample_cnt_q, ones;
    logic [CW-1:0]          pq_w, ec_w, first, last;
    logic                   cfg_bad, at_end, wrap, latch, capture_ok, in_window, vote_now;

    uart_rx_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .UCLK          (UCLK),
        .reset         (reset),
        .serial_data_in(serial_data_in),
        .rx_s          (rx_s)
    );

    // Window math is one bit wider than prescale so first/last never wrap.
    assign pq_w       = CW'(prescale_q);
    assign ec_w       = CW'(edge_count);
    assign first      = (pq_w >> 1) - CW'(NUM_SAMPLES / 2);
    assign last       = first + CW'(NUM_SAMPLES - 1);
    assign cfg_bad    = pq_w < MIN_PRESCALE;
    assign at_end     = (prescale_q != '0) && (ec_w == pq_w - CW'(1));
    assign wrap       = enable && !bit_start && at_end;
    assign latch      = (enable && bit_start) || wrap;
    assign bit_tick   = wrap;
    assign capture_ok = enable && !bit_start && !cfg_bad;
    assign in_window  = capture_ok && (ec_w >= first) && (ec_w < last);
    assign vote_now   = capture_ok && (ec_w == last) && (sample_cnt_q == NW'(NUM_SAMPLES - 1));
    // Stored samples plus the live one form the full vote set.
    assign votes      = NUM_SAMPLES'({samples_q, rx_s});

    always_comb begin
        ones = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) ones = ones + NW'(votes[i]);
    end

    always_ff @(posedge UCLK) begin
        if (reset) begin
            edge_count   <= '0;
            samples_q    <= '0;
            sample_cnt_q <= '0;
            prescale_q   <= prescale;
            sampled_bit  <= RX_IDLE;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            edge_count   <= (!enable || bit_start || prescale_q == '0 || at_end) ? '0 : edge_count + PRESCALE_W'(1);
            samples_q    <= in_window ? votes : '0;
            sample_cnt_q <= in_window ? sample_cnt_q + NW'(1) : '0;
            sample_valid <= vote_now;
            if (vote_now) begin
                sampled_bit <= ones > THRESH;
                noise_err   <= !((&votes) || !(|votes));
            end
            if (latch) begin
                prescale_q <= prescale;
                cfg_err    <= CW'(prescale) < MIN_PRESCALE;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversample_sampler.sv
// tb_uart_rx_oversample_sampler: directed scoreboard bench for the oversampling RX bit sampler.
module tb_uart_rx_oversample_sampler;
    typedef struct {
        logic b;
        logic n;
        int   ec;
    } exp_t;

    logic       UCLK = 1'b0;
    logic       reset, serial_data_in, enable, bit_start;
    logic [5:0] prescale;
    logic       sampled_bit, sample_valid, noise_err, bit_tick, cfg_err;
    logic [5:0] edge_count;

    exp_t sb[$];
    int   mc, pq, checks, errors;
    logic cfgm;

    uart_rx_oversample_sampler dut (
        .UCLK          (UCLK),
        .reset         (reset),
        .serial_data_in(serial_data_in),
        .prescale      (prescale),
        .enable        (enable),
        .bit_start     (bit_start),
        .sampled_bit   (sampled_bit),
        .sample_valid  (sample_valid),
        .noise_err     (noise_err),
        .bit_tick      (bit_tick),
        .edge_count    (edge_count),
        .cfg_err       (cfg_err)
    );

    always #5 UCLK = ~UCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge UCLK);
        if (reset) begin
            mc = 0; pq = int'(prescale); cfgm = 1'b0;
        end else if (!enable) begin
            mc = 0;
        end else if (bit_start) begin
            mc = 0; pq = int'(prescale); cfgm = (prescale < 6'd4);
        end else if (pq == 0) begin
            mc = 0;
        end else if (mc == pq - 1) begin
            mc = 0; pq = int'(prescale); cfgm = (prescale < 6'd4);
        end else begin
            mc++;
        end
        #1;
        check("edge_count", 32'(edge_count), 32'(mc));
        check("bit_tick", 32'(bit_tick), 32'(enable && !bit_start && pq != 0 && mc == pq - 1));
        check("cfg_err", 32'(cfg_err), 32'(cfgm));
        if (sample_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(sample_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sampled_bit", 32'(sampled_bit), 32'(e.b));
                check("noise_err", 32'(noise_err), 32'(e.n));
                check("valid_edge", 32'(edge_count), 32'(e.ec));
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; enable = 1'b0; bit_start = 1'b0; serial_data_in = 1'b1; prescale = 6'd16;
        mc = 0; pq = 16; cfgm = 1'b0;
        run(2);
        check("rst_sampled_bit", 32'(sampled_bit), 32'd1);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_noise_err", 32'(noise_err), 32'd0);
        reset = 1'b0; enable = 1'b1; serial_data_in = 1'b0;
        sb.push_back('{1'b0, 1'b0, 10});
        run(16);
        sb.push_back('{1'b0, 1'b1, 10});
        repeat (16) begin serial_data_in = (mc == 6); step(); end
        serial_data_in = 1'b1;
        sb.push_back('{1'b1, 1'b0, 10});
        run(16);
        sb.push_back('{1'b1, 1'b1, 10});
        repeat (16) begin serial_data_in = (mc != 7); step(); end
        serial_data_in = 1'b0;
        sb.push_back('{1'b0, 1'b0, 10});
        run(4);
        prescale = 6'd8;
        run(12);
        sb.push_back('{1'b0, 1'b0, 6});
        run(8);
        prescale = 6'd16; bit_start = 1'b1;
        step();
        bit_start = 1'b0;
        run(8);
        bit_start = 1'b1;
        step();
        bit_start = 1'b0;
        sb.push_back('{1'b0, 1'b0, 10});
        run(16);
        prescale = 6'd3; bit_start = 1'b1;
        step();
        bit_start = 1'b0;
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        run(12);
        prescale = 6'd8; bit_start = 1'b1;
        step();
        bit_start = 1'b0;
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        sb.push_back('{1'b0, 1'b0, 6});
        run(8);
        prescale = 6'd16; bit_start = 1'b1;
        step();
        bit_start = 1'b0;
        run(8);
        enable = 1'b0;
        step();
        check("dis_sample_valid", 32'(sample_valid), 32'd0);
        check("dis_hold_bit", 32'(sampled_bit), 32'd0);
        run(3);
        enable = 1'b1;
        sb.push_back('{1'b0, 1'b1, 10});
        repeat (16) begin serial_data_in = (mc == 6); step(); end
        serial_data_in = 1'b0;
        run(5);
        reset = 1'b1;
        step();
        check("rst2_sampled_bit", 32'(sampled_bit), 32'd1);
        check("rst2_sample_valid", 32'(sample_valid), 32'd0);
        check("rst2_noise_err", 32'(noise_err), 32'd0);
        check("rst2_edge_count", 32'(edge_count), 32'd0);
        reset = 1'b0;
        run(4);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
